// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// A 32-cycle shift-add / restoring-divide core, followed by sign correction in FIN.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;
  logic [1:0]  state;
  logic [1:0]  op_q;
  logic [31:0] ma, mb, quo, rem;
  logic        sa, sb, dz;
  logic [5:0]  cnt;
  logic [63:0] prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] add_sum, shifted;
  logic        sub_neg;
  logic [31:0] sub;
  logic [63:0] prod_fix;
  logic [31:0] q_fix, r_fix, a_orig, res_hi, res_lo;
  // Magnitudes only for signed ops (op[0]==0); 0x80000000 stays 0x80000000 as unsigned.
  assign a_neg   = ~op[0] & a[31];
  assign b_neg   = ~op[0] & b[31];
  assign a_mag   = a_neg ? -a : a;
  assign b_mag   = b_neg ? -b : b;
  assign add_sum = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, ma} : 33'd0);
  // Remainder is always < divisor, so the successful subtraction fits in 32 bits.
  assign shifted = {rem, quo[31]};
  assign sub_neg = shifted < {1'b0, mb};
  assign sub     = shifted[31:0] - mb;
  assign prod_fix = (sa ^ sb) ? -prod : prod;
  assign q_fix    = (sa ^ sb) ? -quo : quo;
  assign r_fix    = sa ? -rem : rem;
  assign a_orig   = sa ? -ma : ma;
  assign res_hi   = ~op_q[1] ? prod_fix[63:32] : dz ? a_orig : r_fix;
  assign res_lo   = ~op_q[1] ? prod_fix[31:0] : dz ? 32'hFFFF_FFFF : q_fix;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= 2'd0;
      ma    <= '0;
      mb    <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      dz    <= 1'b0;
      cnt   <= '0;
      prod  <= '0;
      rem   <= '0;
      quo   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            op_q  <= op;
            ma    <= a_mag;
            mb    <= b_mag;
            sa    <= a_neg;
            sb    <= b_neg;
            dz    <= (b == 32'd0);
            cnt   <= '0;
            prod  <= {32'd0, b_mag};
            rem   <= '0;
            quo   <= a_mag;
          end else begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
          end
        end
        RUN: begin
          prod <= {add_sum, prod[31:1]};
          rem  <= sub_neg ? shifted[31:0] : sub;
          quo  <= {quo[30:0], ~sub_neg};
          cnt  <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIN;
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          hi    <= res_hi;
          lo    <= res_lo;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
